// File: rtl/sample_unpacker.sv
// sample_unpacker: pops 16-bit words from a show-ahead feed, double-buffers
// them (hold -> shift), and emits one SAMPLE_BITS-wide sample per strobe,
// MSB-first. Underrun is sticky; sample_count survives flush.
module sample_unpacker #(
    parameter int SAMPLE_BITS   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   have_data,
    input  logic [15:0]            data_in,
    output logic                   read_one,
    input  logic                   flush,
    input  logic                   sample_en,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic                   sample_valid,
    output logic                   underrun,
    output logic [31:0]            sample_count
);

    localparam int SPW   = 16 / SAMPLE_BITS;
    localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPW - 1);

    typedef enum logic {
        F_IDLE,
        F_SETTLE
    } fetch_state_t;

    fetch_state_t state, state_nxt;
    logic [2:0]   settle_cnt;

    logic [15:0]      shift_reg;
    logic [IDX_W-1:0] idx;
    logic             shift_valid;
    logic [15:0]      hold_reg;
    logic             hold_valid;

    // The strobe is taking the final sample of the word in the shift register.
    logic last_take;
    assign last_take = sample_en && shift_valid && (idx == IDX_LAST);

    // Fetch state register and settle counter; flush and reset both park in F_IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register sees
        // pre-edge values of the others regardless of block ordering.
        if (!reset_n || flush) begin
            state      <= F_IDLE;
            settle_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (read_one)
                settle_cnt <= 3'(SETTLE_CYCLES);
            else if (state == F_SETTLE)
                settle_cnt <= settle_cnt - 3'd1;
        end
    end

    // Next-state: leave F_SETTLE on the cycle the counter decrements to zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        case (state)
            F_IDLE:   if (read_one) state_nxt = F_SETTLE;
            F_SETTLE: if (settle_cnt == 3'd1) state_nxt = F_IDLE;
            default:  state_nxt = F_IDLE;
        endcase
    end

    // Pop pulse: only from F_IDLE with an empty hold register; never during reset/flush.
    always_comb begin
        read_one = reset_n && !flush && (state == F_IDLE) && have_data && !hold_valid;
    end

    // Datapath: capture into hold, hold->shift transfer, and per-strobe emission.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_reg    <= '0;
            idx          <= '0;
            shift_valid  <= 1'b0;
            hold_reg     <= '0;
            hold_valid   <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            sample_count <= '0;
        end else if (flush) begin
            shift_valid  <= 1'b0;
            hold_valid   <= 1'b0;
            idx          <= '0;
            underrun     <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_en) begin
                if (shift_valid) begin
                    sample_out   <= shift_reg[15 -: SAMPLE_BITS];
                    sample_valid <= 1'b1;
                    shift_reg    <= shift_reg << SAMPLE_BITS;
                    idx          <= idx + 1'b1;
                    sample_count <= sample_count + 32'd1;
                end else begin
                    underrun <= 1'b1;
                end
            end
            // A reload overrides the shift/idx update above when the last sample leaves.
            if (hold_valid && (!shift_valid || last_take)) begin
                shift_reg   <= hold_reg;
                idx         <= '0;
                shift_valid <= 1'b1;
                hold_valid  <= 1'b0;
            end else if (last_take) begin
                shift_valid <= 1'b0;
            end
            // Capture cannot coincide with a transfer: it requires hold to be empty.
            if (read_one) begin
                hold_reg   <= data_in;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sample_unpacker.md
# sample_unpacker

Downstream consumer of the real-time Ethernet data feed. Pops 16-bit words from the feed's show-ahead output, double-buffers them, and emits one packed GPS IF sample per sample strobe, MSB-first, to the correlator front end. Flags sticky underrun when a strobe arrives with no buffered sample, and counts emitted samples for host-side sync.

## Interface
- SAMPLE_BITS, 2, bits per sample; legal values 1, 2, 4, 8; SPW = 16/SAMPLE_BITS samples per word
- SETTLE_CYCLES, 2, idle cycles after each pop before have_data is trusted again (1..7)

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- have_data  in  1  feed has at least one word; data_in valid while high
- data_in  in  16  head word of feed (show-ahead)
- read_one  out  1  one-cycle pop pulse to feed
- flush  in  1  synchronous clear of buffers, underrun and FSM; counter kept
- sample_en  in  1  sample-rate strobe, one cycle wide
- sample_out  out  SAMPLE_BITS  current sample
- sample_valid  out  1  one-cycle pulse, sample_out valid
- underrun  out  1  sticky: strobe arrived with shift buffer empty
- sample_count  out  32  samples emitted, wraps at 2^32

## Operation
- Storage: shift register shift_reg[15:0] + sub-count idx (0..SPW-1) + shift_valid; holding register hold_reg[15:0] + hold_valid.
- Fetch FSM: F_IDLE, F_SETTLE.
  - F_IDLE: if have_data && !hold_valid && !flush -> read_one=1 this cycle, hold_reg<=data_in, hold_valid<=1, go F_SETTLE with counter=SETTLE_CYCLES.
  - F_SETTLE: read_one=0; decrement; at 0 return to F_IDLE. have_data ignored.
- Hold->shift transfer: when hold_valid && (!shift_valid || last sample being consumed this cycle) -> shift_reg<=hold_reg, idx<=0, shift_valid<=1, hold_valid<=0. Fetch needs hold_valid=0, transfer needs hold_valid=1, so they never collide; a fetched word reaches shift no earlier than the next cycle.
- Emission on sample_en:
  - shift_valid=1 -> sample_out<=shift_reg[15:16-SAMPLE_BITS], sample_valid<=1, shift left by SAMPLE_BITS, idx++, sample_count++. On idx==SPW-1, word consumed: reload from hold if hold_valid, else shift_valid<=0.
  - shift_valid=0 -> underrun<=1, sample_valid<=0, sample_out holds, count unchanged. A word arriving in hold the same cycle does not rescue that strobe.
- sample_en while reset_n=0 or flush=1: ignored.
- flush: shift_valid, hold_valid, idx, underrun <=0; FSM to F_IDLE; read_one=0 that cycle. sample_count not cleared.
- Reset values (reset_n=0 at edge): read_one=0, sample_out=0, sample_valid=0, underrun=0, sample_count=0, both buffers empty, FSM F_IDLE. Reset mid-SETTLE or mid-word discards data; a pop already issued is not replayed.

## Timing
- read_one is combinational from registered state and have_data, asserted in the capture cycle; feed pops on that edge.
- Max pop rate: one word per SETTLE_CYCLES+1 clocks (3 at default).
- sample_en -> sample_valid/sample_out: 1 cycle latency, registered.
- First sample: have_data rises at cycle 0 -> pop at cycle 0, hold at 1, shift at 2; earliest valid emission from a strobe at cycle 2, sample_valid at cycle 3.
- Sustainable strobe rate: no faster than SPW samples per SETTLE_CYCLES+1 clocks. Faster strobing underruns and is flagged, never corrupts ordering.
- Back-to-back sample_en (every cycle) is legal while buffered data lasts.

## Test plan
- SAMPLE_BITS=2, feed one word 16'hE41B, then 8 strobes 4 cycles apart -> samples 3,2,1,0,0,1,2,3, sample_count=8, underrun=0, exactly one read_one pulse.
- Feed holds 3 words (have_data=1 throughout) -> read_one pulses at cycles 0, 3, 6 only while hold empties; no pop while hold_valid=1; 24 samples in word order.
- No data, strobe at cycle 5 -> underrun=1 from cycle 6 and stays set; sample_valid never pulses; count stays 0.
- Strobe every cycle with SAMPLE_BITS=8, feed always ready -> underrun sets once shift drains faster than refill; all emitted samples correct and in order.
- flush during F_SETTLE with a half-consumed word -> next strobe underruns, sample_count preserved, next have_data produces fresh pop within 1 cycle.
- reset_n low for 1 cycle mid-stream -> all outputs at reset values next cycle, count=0, fetch restarts from next feed word.
